led_scheduler: RTL and testbench

LED_SCHEDULER -- requirements
Module: led_scheduler

---
 rtl/led_scheduler.sv | 145 ++++++++++++++
 tb/tb_led_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scheduler.sv
// LED scheduler: shows the synchronized code live, flashes it on a change and
// runs a one-hot walking self-test on request.
module led_scheduler #(
   parameter int unsigned TICK_DIV    = 13500000,
   parameter int unsigned FLASH_COUNT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] binary_code,
   input  logic       test_req,
   output logic [3:0] leds_code,
   output logic       busy
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned PW = $clog2(FLASH_COUNT + 1);

   typedef enum logic [1:0] {
      LIVE  = 2'b00,
      FLASH = 2'b01,
      TEST  = 2'b10
   } state_t;

   state_t        state;
   logic [3:0]    code_meta, code_s, code_prev;
   logic          req_meta, req_s, req_prev;
   logic [CW-1:0] cnt;
   logic [PW-1:0] pairs;
   logic          show;
   logic [2:0]    idx;
   logic          req_pulse, change, tick;

   assign req_pulse = req_s & ~req_prev;
   assign change    = (code_s != code_prev);
   assign tick      = (cnt == CW'(TICK_DIV - 1));

   function automatic logic [3:0] test_pattern(input logic [2:0] i);
      case (i)
         3'd0:    test_pattern = 4'b0001;
         3'd1:    test_pattern = 4'b0010;
         3'd2:    test_pattern = 4'b0100;
         3'd3:    test_pattern = 4'b1000;
         default: test_pattern = 4'b1111;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_meta <= '0;
         code_s    <= '0;
         code_prev <= '0;
         req_meta  <= 1'b0;
         req_s     <= 1'b0;
         req_prev  <= 1'b0;
      end else begin
         code_meta <= binary_code;
         code_s    <= code_meta;
         code_prev <= code_s;
         req_meta  <= test_req;
         req_s     <= req_meta;
         req_prev  <= req_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LIVE;
         leds_code <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
         pairs     <= '0;
         show      <= 1'b0;
         idx       <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         case (state)
            LIVE: begin
               leds_code <= code_s;
               busy      <= 1'b0;
               if (req_pulse) begin
                  state     <= TEST;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  idx       <= '0;
                  leds_code <= test_pattern(3'd0);
               end else if (change) begin
                  state     <= FLASH;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  pairs     <= '0;
                  show      <= 1'b0;
                  leds_code <= '0;
               end
            end
            FLASH: begin
               leds_code <= show ? code_s : 4'b0000;
               if (req_pulse) begin
                  state     <= TEST;
                  cnt       <= '0;
                  idx       <= '0;
                  leds_code <= test_pattern(3'd0);
               end else if (change) begin
                  // A new code restarts the whole flash from its blank phase
                  cnt       <= '0;
                  pairs     <= '0;
                  show      <= 1'b0;
                  leds_code <= '0;
               end else if (tick) begin
                  if (!show) begin
                     show      <= 1'b1;
                     leds_code <= code_s;
                  end else if (pairs == PW'(FLASH_COUNT - 1)) begin
                     state     <= LIVE;
                     busy      <= 1'b0;
                     leds_code <= code_s;
                  end else begin
                     pairs     <= pairs + 1'b1;
                     show      <= 1'b0;
                     leds_code <= '0;
                  end
               end
            end
            TEST: begin
               if (tick) begin
                  if (idx == 3'd4) begin
                     state     <= LIVE;
                     busy      <= 1'b0;
                     leds_code <= code_s;
                  end else begin
                     idx       <= idx + 3'd1;
                     leds_code <= test_pattern(idx + 3'd1);
                  end
               end
            end
            default: begin
               state     <= LIVE;
               busy      <= 1'b0;
               cnt       <= '0;
               leds_code <= code_s;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_scheduler.sv
// Directed self-checking bench for led_scheduler with TICK_DIV=4, FLASH_COUNT=2.
module tb_led_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] binary_code;
   logic       test_req;
   logic [3:0] leds_code;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   led_scheduler #(
      .TICK_DIV    (4),
      .FLASH_COUNT (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .binary_code (binary_code),
      .test_req    (test_req),
      .leds_code   (leds_code),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      bit found;
      rst = 1'b1; binary_code = 4'b0000; test_req = 1'b1;
      cycles(3);
      n_cmp++; if (leds_code !== 4'b0000) begin n_fail++;
         $display("FAIL reset_leds: got %b expected 0000", leds_code); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found) begin n_fail++;
         $display("FAIL held_req_pulse: busy got 0 expected 1 within 4 edges"); end
      n_cmp++; if (leds_code !== 4'b0001) begin n_fail++;
         $display("FAIL held_req_test: got %b expected 0001", leds_code); end
      test_req = 1'b0;
      for (int i = 0; i < 30 && busy; i++) cycles(1);
      n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b0000) begin n_fail++;
         $display("FAIL held_req_end: got busy=%b leds=%b expected 0/0000", busy, leds_code); end
   endtask

   task automatic test_flash();
      bit found;
      logic [3:0] exp;
      binary_code = 4'b0101;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found) begin n_fail++;
         $display("FAIL flash_latency: busy got 0 expected 1 within 4 edges"); end
      for (int k = 0; k < 16; k++) begin
         exp = ((k / 4) % 2 == 1) ? 4'b0101 : 4'b0000;
         n_cmp++; if (leds_code !== exp || busy !== 1'b1) begin n_fail++;
            $display("FAIL flash_seq[%0d]: got busy=%b leds=%b expected 1/%b",
                     k, busy, leds_code, exp); end
         cycles(1);
      end
      n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b0101) begin n_fail++;
         $display("FAIL flash_end: got busy=%b leds=%b expected 0/0101", busy, leds_code); end
   endtask

   task automatic test_selftest();
      bit found;
      logic [3:0] pat [5];
      pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100;
      pat[3] = 4'b1000; pat[4] = 4'b1111;
      test_req = 1'b1;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found) begin n_fail++;
         $display("FAIL test_entry: busy got 0 expected 1 within 4 edges"); end
      for (int k = 0; k < 20; k++) begin
         n_cmp++; if (leds_code !== pat[k/4] || busy !== 1'b1) begin n_fail++;
            $display("FAIL test_seq[%0d]: got busy=%b leds=%b expected 1/%b",
                     k, busy, leds_code, pat[k/4]); end
         cycles(1);
      end
      n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b0101) begin n_fail++;
         $display("FAIL test_end: got busy=%b leds=%b expected 0/0101", busy, leds_code); end
      test_req = 1'b0;
      cycles(2);
   endtask

   task automatic test_restart();
      bit found;
      logic [3:0] exp;
      binary_code = 4'b0011;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found) begin n_fail++;
         $display("FAIL restart_entry: busy got 0 expected 1 within 4 edges"); end
      cycles(4);
      n_cmp++; if (leds_code !== 4'b0011) begin n_fail++;
         $display("FAIL restart_show: got %b expected 0011", leds_code); end
      binary_code = 4'b1100;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = (leds_code == 4'b0000); end
      n_cmp++; if (!found) begin n_fail++;
         $display("FAIL restart_blank: leds got %b expected 0000 within 4 edges", leds_code); end
      for (int k = 0; k < 16; k++) begin
         exp = ((k / 4) % 2 == 1) ? 4'b1100 : 4'b0000;
         n_cmp++; if (leds_code !== exp || busy !== 1'b1) begin n_fail++;
            $display("FAIL restart_seq[%0d]: got busy=%b leds=%b expected 1/%b",
                     k, busy, leds_code, exp); end
         cycles(1);
      end
      n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b1100) begin n_fail++;
         $display("FAIL restart_end: got busy=%b leds=%b expected 0/1100", busy, leds_code); end
   endtask

   task automatic test_req_and_change();
      bit found;
      binary_code = 4'b0110; test_req = 1'b1;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found || leds_code !== 4'b0001) begin n_fail++;
         $display("FAIL prio_test: got busy=%b leds=%b expected 1/0001", busy, leds_code); end
      cycles(2);
      binary_code = 4'b1001; test_req = 1'b0;
      cycles(2);
      n_cmp++; if (busy !== 1'b1 || leds_code !== 4'b0010) begin n_fail++;
         $display("FAIL test_ignores_code: got busy=%b leds=%b expected 1/0010",
                  busy, leds_code); end
      cycles(16);
      n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b1001) begin n_fail++;
         $display("FAIL prio_end: got busy=%b leds=%b expected 0/1001", busy, leds_code); end
      for (int k = 0; k < 12; k++) begin
         cycles(1);
         n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b1001) begin n_fail++;
            $display("FAIL no_flash_after_test[%0d]: got busy=%b leds=%b expected 0/1001",
                     k, busy, leds_code); end
      end
   endtask

   task automatic test_async_reset();
      bit found;
      test_req = 1'b1;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found) begin n_fail++;
         $display("FAIL areset_entry: busy got 0 expected 1 within 4 edges"); end
      cycles(9);
      n_cmp++; if (leds_code !== 4'b0100) begin n_fail++;
         $display("FAIL areset_step3: got %b expected 0100", leds_code); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (leds_code !== 4'b0000 || busy !== 1'b0) begin n_fail++;
         $display("FAIL areset_immediate: got busy=%b leds=%b expected 0/0000",
                  busy, leds_code); end
      test_req = 1'b0; binary_code = 4'b0011;
      cycles(2);
      rst = 1'b0;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n_cmp++; if (!found || leds_code !== 4'b0000) begin n_fail++;
         $display("FAIL areset_flash: got busy=%b leds=%b expected 1/0000", busy, leds_code); end
      for (int i = 0; i < 30 && busy; i++) cycles(1);
      n_cmp++; if (busy !== 1'b0 || leds_code !== 4'b0011) begin n_fail++;
         $display("FAIL areset_flash_end: got busy=%b leds=%b expected 0/0011",
                  busy, leds_code); end
   endtask

   task automatic test_tick_aligned();
      bit found;
      int n;
      binary_code = 4'b0101;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      for (int i = 0; i < 30 && busy; i++) cycles(1);
      // LIVE was entered at the last edge with the step counter cleared, so a
      // change applied one edge later is detected on the fourth LIVE edge: a tick.
      cycles(1);
      binary_code = 4'b0110;
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin cycles(1); found = busy; end
      n = 0;
      for (int i = 0; i < 40 && busy; i++) begin n++; cycles(1); end
      n_cmp++; if (n != 16) begin n_fail++;
         $display("FAIL tick_aligned_len: got %0d cycles expected 16", n); end
      n_cmp++; if (leds_code !== 4'b0110) begin n_fail++;
         $display("FAIL tick_aligned_end: got %b expected 0110", leds_code); end
   endtask

   initial begin
      rst = 1'b1; binary_code = 4'b0000; test_req = 1'b0;
      test_reset();
      test_flash();
      test_selftest();
      test_restart();
      test_req_and_change();
      test_async_reset();
      test_tick_aligned();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
